// File: rtl/pgm_bus_pkg.sv
// rtl/pgm_bus_pkg.sv - shared types and helpers for the 68K video RAM bridge
package pgm_bus_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD_WAIT,
      RD_DATA,
      WR_COMMIT,
      WAIT,
      ACK,
      HOLD
   } bridge_state_t;

   localparam int WAIT_W = 4;

   // Strobes are active low: a low strobe takes that byte from new_word.
   function automatic logic [15:0] byte_merge(
      input logic [15:0] old_word,
      input logic [15:0] new_word,
      input logic        uds_n,
      input logic        lds_n
   );
      byte_merge = {uds_n ? old_word[15:8] : new_word[15:8],
                    lds_n ? old_word[7:0]  : new_word[7:0]};
   endfunction

endpackage

// File: rtl/m68k_vram_bridge.sv
// rtl/m68k_vram_bridge.sv - 68000 bus cycle to single-port video RAM access bridge
module m68k_vram_bridge
   import pgm_bus_pkg::*;
#(
   parameter int ADDR_WIDTH  = 16,
   parameter int WAIT_STATES = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cpu_cs,
   input  logic                  cpu_as_n,
   input  logic                  cpu_rw,
   input  logic                  cpu_uds_n,
   input  logic                  cpu_lds_n,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [15:0]           cpu_din,
   output logic [15:0]           cpu_dout,
   output logic                  cpu_dtack_n,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [15:0]           ram_din,
   input  logic [15:0]           ram_dout
);

   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_STATES);

   bridge_state_t     state;
   logic [WAIT_W-1:0] wait_cnt;
   logic [15:0]       lat_din;
   logic              lat_rw;
   logic              lat_uds_n;
   logic              lat_lds_n;
   logic              aborted;
   logic              served;
   logic              start;

   // served keeps one AS assertion from being taken twice.
   assign start = (state == IDLE) && cpu_cs && !cpu_as_n && (!cpu_uds_n || !cpu_lds_n) && !served;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         wait_cnt    <= '0;
         lat_din     <= '0;
         lat_rw      <= 1'b1;
         lat_uds_n   <= 1'b1;
         lat_lds_n   <= 1'b1;
         aborted     <= 1'b0;
         served      <= 1'b0;
         cpu_dout    <= '0;
         cpu_dtack_n <= 1'b1;
         ram_we      <= 1'b0;
         ram_addr    <= '0;
         ram_din     <= '0;
      end else begin
         if (cpu_as_n)
            served <= 1'b0;
         if (cpu_as_n && state != IDLE)
            aborted <= 1'b1;
         case (state)
            IDLE: begin
               if (start) begin
                  ram_addr  <= cpu_addr;
                  lat_din   <= cpu_din;
                  lat_rw    <= cpu_rw;
                  lat_uds_n <= cpu_uds_n;
                  lat_lds_n <= cpu_lds_n;
                  served    <= 1'b1;
                  aborted   <= 1'b0;
                  wait_cnt  <= '0;
                  if (!cpu_rw && !cpu_uds_n && !cpu_lds_n) begin
                     ram_din <= cpu_din;
                     ram_we  <= 1'b1;
                     state   <= WR_COMMIT;
                  end else begin
                     // Reads and byte writes both begin by fetching the word.
                     state <= RD_WAIT;
                  end
               end else if (!cpu_as_n && served) begin
                  state <= HOLD;
               end
            end
            RD_WAIT:
               state <= RD_DATA;
            RD_DATA: begin
               if (lat_rw) begin
                  cpu_dout <= ram_dout;
                  state    <= WAIT;
               end else begin
                  ram_din <= byte_merge(ram_dout, lat_din, lat_uds_n, lat_lds_n);
                  ram_we  <= 1'b1;
                  state   <= WR_COMMIT;
               end
            end
            WR_COMMIT: begin
               ram_we <= 1'b0;
               state  <= WAIT;
            end
            WAIT: begin
               if (aborted || cpu_as_n) begin
                  state <= IDLE;
               end else if (wait_cnt == WAIT_LAST) begin
                  cpu_dtack_n <= 1'b0;
                  state       <= ACK;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            ACK: begin
               if (cpu_as_n) begin
                  cpu_dtack_n <= 1'b1;
                  state       <= IDLE;
               end
            end
            HOLD: begin
               if (cpu_as_n)
                  state <= IDLE;
            end
            default:
               state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_m68k_vram_bridge.sv
// tb/tb_m68k_vram_bridge.sv - scoreboard bench for m68k_vram_bridge (0 and 3 wait states)
`timescale 1ns/1ps
module tb_m68k_vram_bridge;

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] d;
   } wr_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, cs0, cs3, as_n, rw, uds_n, lds_n;
   logic [15:0] addr, din;
   logic [15:0] dout0, dout3, rdout0, rdout3, rdin0, rdin3, raddr0, raddr3;
   logic        dtack0, dtack3, we0, we3;

   m68k_vram_bridge #(.ADDR_WIDTH(16), .WAIT_STATES(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .cpu_cs(cs0), .cpu_as_n(as_n), .cpu_rw(rw),
      .cpu_uds_n(uds_n), .cpu_lds_n(lds_n), .cpu_addr(addr), .cpu_din(din),
      .cpu_dout(dout0), .cpu_dtack_n(dtack0), .ram_we(we0), .ram_addr(raddr0),
      .ram_din(rdin0), .ram_dout(rdout0)
   );

   m68k_vram_bridge #(.ADDR_WIDTH(16), .WAIT_STATES(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .cpu_cs(cs3), .cpu_as_n(as_n), .cpu_rw(rw),
      .cpu_uds_n(uds_n), .cpu_lds_n(lds_n), .cpu_addr(addr), .cpu_din(din),
      .cpu_dout(dout3), .cpu_dtack_n(dtack3), .ram_we(we3), .ram_addr(raddr3),
      .ram_din(rdin3), .ram_dout(rdout3)
   );

   logic [15:0] mem0 [0:65535];
   logic [15:0] mem3 [0:65535];

   always @(posedge clk) begin
      if (we0) mem0[raddr0] <= rdin0;
      rdout0 <= mem0[raddr0];
      if (we3) mem3[raddr3] <= rdin3;
      rdout3 <= mem3[raddr3];
   end

   int          n_checks = 0;
   int          n_pass   = 0;
   int          wcnt0    = 0;
   int          wcnt3    = 0;
   wr_t         wq0[$];
   wr_t         wq3[$];
   logic [15:0] rq[$];
   logic [15:0] model [int];
   wr_t         e0, e3;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic dtk(input bit s);
      return s ? dtack3 : dtack0;
   endfunction

   always @(negedge clk) begin
      if (we0) begin
         wcnt0++;
         if (wq0.size() == 0) check("unexpected_we0", 1, 0);
         else begin
            e0 = wq0.pop_front();
            check("we0_addr", raddr0, e0.a);
            check("we0_data", rdin0, e0.d);
         end
      end
      if (we3) begin
         wcnt3++;
         if (wq3.size() == 0) check("unexpected_we3", 1, 0);
         else begin
            e3 = wq3.pop_front();
            check("we3_addr", raddr3, e3.a);
            check("we3_data", rdin3, e3.d);
         end
      end
   end

   task automatic bus_cycle(input bit sel, input bit rd, input bit u_n, input bit l_n,
                            input logic [15:0] a, input logic [15:0] d,
                            input int exp_lat, input int hold);
      int          n, key, wb;
      logic [15:0] old, nw;
      key = sel ? 65536 + int'(a) : int'(a);
      old = model.exists(key) ? model[key] : 16'h0000;
      if (rd) rq.push_back(old);
      else begin
         nw = {u_n ? old[15:8] : d[15:8], l_n ? old[7:0] : d[7:0]};
         model[key] = nw;
         if (sel) wq3.push_back(wr_t'{a: a, d: nw});
         else     wq0.push_back(wr_t'{a: a, d: nw});
      end
      wb = sel ? wcnt3 : wcnt0;
      @(negedge clk);
      cs0 = !sel; cs3 = sel; as_n = 1'b0; rw = rd; uds_n = u_n; lds_n = l_n; addr = a; din = d;
      n = 0;
      do begin
         @(posedge clk);
         @(negedge clk);
         n++;
         // Bus lines wander after start; the bridge must use its latched copy.
         if (n == 1) begin
            addr = ~a; din = ~d; cs0 = 1'b0; cs3 = 1'b0;
         end
      end while (dtk(sel) && n < 40);
      check(rd ? "rd_latency" : "wr_latency", n - 1, exp_lat);
      if (rd) check("rd_data", sel ? dout3 : dout0, rq.pop_front());
      if (hold > 0) begin
         repeat (hold) @(negedge clk);
         check("dtack_held", dtk(sel), 1'b0);
         if (rd) check("rd_data_held", sel ? dout3 : dout0, old);
      end
      as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
      @(negedge clk);
      check("dtack_release", dtk(sel), 1'b1);
      @(negedge clk);
      check("we_count", (sel ? wcnt3 : wcnt0) - wb, rd ? 0 : 1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int          b;
      bit          seen;
      logic [15:0] ra, rdv;
      rst_n = 1'b0; cs0 = 1'b0; cs3 = 1'b0; as_n = 1'b1; rw = 1'b1;
      uds_n = 1'b1; lds_n = 1'b1; addr = '0; din = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_dtack", dtack0, 1'b1);
      check("rst_we", we0, 1'b0);
      check("rst_dout", dout0, 16'h0000);
      check("rst_addr", raddr0, 16'h0000);
      check("rst_dtack3", dtack3, 1'b1);
      rst_n = 1'b1;

      bus_cycle(0, 0, 0, 0, 16'h0123, 16'hBEEF, 2, 0);
      bus_cycle(0, 1, 0, 0, 16'h0123, 16'h0000, 3, 0);
      bus_cycle(0, 0, 0, 0, 16'h0010, 16'h1234, 2, 0);
      bus_cycle(0, 0, 0, 1, 16'h0010, 16'hAB55, 4, 0);
      bus_cycle(0, 0, 1, 0, 16'h0010, 16'h99CD, 4, 0);
      bus_cycle(0, 1, 0, 0, 16'h0010, 16'h0000, 3, 0);
      check("byte_merge_final", model[16'h0010], 16'hABCD);

      bus_cycle(0, 0, 0, 0, 16'h0077, 16'hC0DE, 2, 20);
      bus_cycle(0, 1, 0, 1, 16'h0077, 16'h0000, 3, 20);

      // Abort: AS negated half a clock after start of a word write.
      model[16'h0200] = 16'h5A5A;
      wq0.push_back(wr_t'{a: 16'h0200, d: 16'h5A5A});
      b = wcnt0;
      @(negedge clk);
      cs0 = 1'b1; as_n = 1'b0; rw = 1'b0; uds_n = 1'b0; lds_n = 1'b0; addr = 16'h0200; din = 16'h5A5A;
      @(negedge clk);
      as_n = 1'b1; cs0 = 1'b0; uds_n = 1'b1; lds_n = 1'b1;
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (!dtack0) seen = 1'b1;
      end
      check("abort_no_dtack", seen, 1'b0);
      check("abort_we_count", wcnt0 - b, 1);
      bus_cycle(0, 1, 0, 0, 16'h0200, 16'h0000, 3, 0);

      for (int i = 0; i < 4; i++) begin
         ra  = 16'(($urandom_range(0, 255) << 4) | 4'h3);
         rdv = 16'($urandom);
         bus_cycle(0, 0, 0, 0, ra, rdv, 2, 0);
         bus_cycle(0, 1, 0, 0, ra, 16'h0000, 3, 0);
      end

      bus_cycle(1, 0, 0, 0, 16'h0040, 16'h1111, 5, 0);
      bus_cycle(1, 1, 0, 0, 16'h0040, 16'h0000, 6, 0);

      // Reset pulsed in the middle of a read on the wait-state instance.
      b = wcnt3;
      @(negedge clk);
      cs3 = 1'b1; as_n = 1'b0; rw = 1'b1; uds_n = 1'b0; lds_n = 1'b0; addr = 16'h0040;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0; as_n = 1'b1; cs3 = 1'b0; uds_n = 1'b1; lds_n = 1'b1;
      repeat (2) @(negedge clk);
      check("midrst_dtack", dtack3, 1'b1);
      check("midrst_dout", dout3, 16'h0000);
      check("midrst_addr", raddr3, 16'h0000);
      check("midrst_we_count", wcnt3 - b, 0);
      rst_n = 1'b1;

      bus_cycle(1, 1, 0, 0, 16'h0040, 16'h0000, 6, 0);
      bus_cycle(1, 0, 1, 0, 16'h0040, 16'h22EE, 7, 0);
      bus_cycle(1, 1, 0, 0, 16'h0040, 16'h0000, 6, 0);

      repeat (3) @(negedge clk);
      check("wq0_drained", wq0.size(), 0);
      check("wq3_drained", wq3.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
